vdg_row_prefetch: RTL and testbench

- Upstream feeder for the MC6847-style VGA display generator. It answers the generator's 12-bit display address (DA) with display data (DD) out of a two-entry, 32-byte row cache.
- The cache is filled by 16-beat bursts from the SDRAM controller's read port.
- It prefetches row N+1 while row N is being displayed. SDRAM latency is therefore hidden from the pixel pipeline.
- CPU writes to video memory invalidate the cache through a flush pulse.

---
 rtl/vdg_row_prefetch.sv | 178 +++++++++++++++++
 tb/tb_vdg_row_prefetch.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vdg_row_prefetch.sv
// Two-entry, 32-byte row cache that answers the display generator's DA with DD
// and fills rows from SDRAM in 16-beat bursts, prefetching the next row while one is displayed.
module vdg_row_prefetch #(
    parameter logic [23:0] BASE_ADDR   = 24'h000000,
    parameter int          BURST_WORDS = 16
) (
    input  logic        clk_25,
    input  logic        reset,
    input  logic [11:0] DA,
    output logic [7:0]  DD,
    input  logic        flush,
    output logic        mem_req,
    output logic [23:0] mem_addr,
    input  logic        mem_ack,
    input  logic        mem_rvalid,
    input  logic [15:0] mem_rdata,
    output logic        underrun,
    output logic [1:0]  o_fsm_state
);

    // Handshake: mem_req rises with a stable mem_addr and holds until the one-clock
    // mem_ack; after that, each mem_rvalid clock carries one beat, gaps allowed.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RECV = 2'd2
    } state_t;

    localparam logic [3:0] LAST_BEAT = 4'(BURST_WORDS - 1);

    state_t     r_state;
    state_t     w_state_next;

    logic [7:0] r_buf0 [32];
    logic [7:0] r_buf1 [32];
    logic [1:0] r_valid;
    logic [6:0] r_tag0;
    logic [6:0] r_tag1;
    logic       r_lru;
    logic [3:0] r_cnt;
    logic       r_flush_pending;
    logic [6:0] r_fetch_row;
    logic       r_fetch_buf;

    logic [6:0] w_row;
    logic [4:0] w_byte;
    logic [6:0] w_next_row;
    logic       w_hit0;
    logic       w_hit1;
    logic       w_next_in0;
    logic       w_next_in1;
    logic       w_launch;
    logic [6:0] w_launch_row;
    logic       w_launch_buf;
    logic       w_beat;
    logic       w_last;

    assign w_row       = DA[11:5];
    assign w_byte      = DA[4:0];
    assign w_next_row  = w_row + 7'd1;
    assign w_hit0      = r_valid[0] && (r_tag0 == w_row);
    assign w_hit1      = r_valid[1] && (r_tag1 == w_row);
    assign w_next_in0  = r_valid[0] && (r_tag0 == w_next_row);
    assign w_next_in1  = r_valid[1] && (r_tag1 == w_next_row);
    assign o_fsm_state = r_state;

    always_ff @(posedge clk_25) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_launch     = 1'b0;
        w_launch_row = w_row;
        w_launch_buf = r_lru;
        w_beat       = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            S_IDLE: begin
                // A flush in the same clock suppresses the launch; the decision reruns next clock.
                if (!flush) begin
                    if (!w_hit0 && !w_hit1) begin
                        w_launch     = 1'b1;
                        w_launch_row = w_row;
                        w_launch_buf = r_lru;
                    end else if (w_hit0 && !w_hit1 && !w_next_in1) begin
                        w_launch     = 1'b1;
                        w_launch_row = w_next_row;
                        w_launch_buf = 1'b1;
                    end else if (w_hit1 && !w_hit0 && !w_next_in0) begin
                        w_launch     = 1'b1;
                        w_launch_row = w_next_row;
                        w_launch_buf = 1'b0;
                    end
                end
                if (w_launch) w_state_next = S_REQ;
            end
            S_REQ: begin
                if (mem_ack) w_state_next = S_RECV;
            end
            S_RECV: begin
                if (mem_rvalid) begin
                    w_beat = 1'b1;
                    if (r_cnt == LAST_BEAT) begin
                        w_last       = 1'b1;
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_25) begin
        if (reset) begin
            DD              <= 8'h00;
            underrun        <= 1'b0;
            mem_req         <= 1'b0;
            mem_addr        <= 24'h0;
            r_valid         <= 2'b00;
            r_tag0          <= 7'd0;
            r_tag1          <= 7'd0;
            r_lru           <= 1'b0;
            r_cnt           <= 4'd0;
            r_flush_pending <= 1'b0;
            r_fetch_row     <= 7'd0;
            r_fetch_buf     <= 1'b0;
        end else begin
            DD       <= w_hit0 ? r_buf0[w_byte] : (w_hit1 ? r_buf1[w_byte] : 8'h00);
            underrun <= ~(w_hit0 | w_hit1);
            if (w_hit0)      r_lru <= 1'b1;
            else if (w_hit1) r_lru <= 1'b0;

            if (w_launch) begin
                r_fetch_row          <= w_launch_row;
                r_fetch_buf          <= w_launch_buf;
                r_valid[w_launch_buf] <= 1'b0;
                mem_addr             <= BASE_ADDR + {13'd0, w_launch_row, 4'b0000};
                mem_req              <= 1'b1;
            end

            if (r_state == S_REQ && mem_ack) begin
                mem_req <= 1'b0;
                r_cnt   <= 4'd0;
            end

            if (w_beat) r_cnt <= r_cnt + 4'd1;

            if (flush) begin
                r_valid <= 2'b00;
                if (r_state != S_IDLE) r_flush_pending <= 1'b1;
            end

            // Completion clears the pending flag even if a flush lands on the last beat;
            // that flush still leaves the new entry invalid through the valid term.
            if (w_last) begin
                if (r_fetch_buf) r_tag1 <= r_fetch_row;
                else             r_tag0 <= r_fetch_row;
                r_valid[r_fetch_buf] <= ~(r_flush_pending | flush);
                r_flush_pending      <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_25) begin
        if (w_beat && !reset) begin
            if (r_fetch_buf) begin
                r_buf1[{r_cnt, 1'b0}] <= mem_rdata[7:0];
                r_buf1[{r_cnt, 1'b1}] <= mem_rdata[15:8];
            end else begin
                r_buf0[{r_cnt, 1'b0}] <= mem_rdata[7:0];
                r_buf0[{r_cnt, 1'b1}] <= mem_rdata[15:8];
            end
        end
    end

endmodule

// File: tb/tb_vdg_row_prefetch.sv
// Bench for vdg_row_prefetch: acts as the SDRAM controller over a row image and
// checks every read and request against a two-entry cache model with LRU.
module tb_vdg_row_prefetch;

    localparam logic [23:0] BASE = 24'hFFF900;

    logic        clk_25 = 1'b0;
    logic        reset;
    logic [11:0] DA;
    logic        flush;
    logic        mem_ack;
    logic        mem_rvalid;
    logic [15:0] mem_rdata;
    logic [7:0]  DD;
    logic        mem_req;
    logic [23:0] mem_addr;
    logic        underrun;
    logic [1:0]  fsm_state;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0] img [128][32];
    bit         m_valid [2];
    logic [6:0] m_tag [2];
    int         m_lru;
    logic [7:0] m_data [2][32];
    int         g_flush_beat = -1;
    int         g_reset_beat = -1;
    logic [6:0] rowset [6];

    vdg_row_prefetch #(.BASE_ADDR(BASE), .BURST_WORDS(16)) dut (
        .clk_25(clk_25), .reset(reset), .DA(DA), .DD(DD), .flush(flush),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .underrun(underrun),
        .o_fsm_state(fsm_state)
    );

    always #20 clk_25 = ~clk_25;

    initial begin
        #4ms;
        $display("FAIL watchdog: observed no finish, expected finish before 4ms");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_25);
        #1;
    endtask

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int hit_idx(input logic [11:0] da);
        for (int k = 0; k < 2; k++)
            if (m_valid[k] && m_tag[k] == da[11:5]) return k;
        return -1;
    endfunction

    function automatic void model_touch(input logic [11:0] da);
        int k;
        k = hit_idx(da);
        if (k >= 0) m_lru = 1 - k;
    endfunction

    function automatic void model_reset();
        m_valid = '{0, 0};
        m_tag   = '{7'd0, 7'd0};
        m_lru   = 0;
    endfunction

    // Which row must be fetched next for this address, and into which entry.
    function automatic bit predict(input logic [11:0] da, output logic [6:0] row, output int bi);
        int k;
        logic [6:0] nxt;
        k   = hit_idx(da);
        nxt = da[11:5] + 7'd1;
        if (k < 0) begin
            row = da[11:5];
            bi  = m_lru;
            return 1'b1;
        end
        row = nxt;
        bi  = 1 - k;
        if (m_valid[bi] && m_tag[bi] == nxt) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [7:0] exp_dd(input logic [11:0] da);
        int k;
        k = hit_idx(da);
        if (k < 0) return 8'h00;
        return m_data[k][da[4:0]];
    endfunction

    task automatic chk_reset_outputs();
        chk("rst_dd", 24'(DD), 24'h0);
        chk("rst_req", 24'(mem_req), 24'h0);
        chk("rst_addr", mem_addr, 24'h0);
        chk("rst_underrun", 24'(underrun), 24'h0);
    endtask

    task automatic serve_fill();
        logic [6:0]  row;
        int          bi;
        int          waited;
        logic [23:0] a;
        bit          flushed;
        bit          other_v;
        logic [6:0]  other_tag;
        logic [11:0] save_da;
        logic [7:0]  e_dd;
        logic        e_un;
        flushed = 1'b0;
        void'(predict(DA, row, bi));
        waited = 0;
        while (mem_req !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        if (mem_req !== 1'b1) begin
            chk("req_timeout", 24'(mem_req), 24'h1);
            return;
        end
        a = BASE + {13'd0, row, 4'd0};
        chk("mem_addr", mem_addr, a);
        m_valid[bi] = 1'b0;
        // Beats presented before the ack must be ignored.
        repeat ($urandom_range(1, 4)) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 16'($urandom);
            tick();
            chk("req_hold", 24'(mem_req), 24'h1);
            chk("addr_hold", mem_addr, a);
        end
        mem_rvalid = 1'b0;
        mem_ack    = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("req_drop", 24'(mem_req), 24'h0);
        for (int k = 0; k < 16; k++) begin
            repeat ($urandom_range(0, 2)) tick();
            mem_rvalid = 1'b1;
            mem_rdata  = {img[row][2*k+1], img[row][2*k]};
            if (k == g_reset_beat) begin
                g_reset_beat = -1;
                reset = 1'b1;
                tick();
                reset      = 1'b0;
                mem_rvalid = 1'b0;
                model_reset();
                chk_reset_outputs();
                return;
            end
            e_dd = exp_dd(DA);
            e_un = (hit_idx(DA) < 0);
            tick();
            mem_rvalid = 1'b0;
            chk("fill_dd", 24'(DD), 24'(e_dd));
            chk("fill_underrun", 24'(underrun), 24'(e_un));
            if (k == g_flush_beat) begin
                g_flush_beat = -1;
                other_v   = m_valid[1-bi];
                other_tag = m_tag[1-bi];
                flush = 1'b1;
                tick();
                flush   = 1'b0;
                m_valid = '{0, 0};
                flushed = 1'b1;
                if (other_v) begin
                    save_da = DA;
                    DA = {other_tag, 5'd0};
                    tick();
                    chk("flush_other_underrun", 24'(underrun), 24'h1);
                    chk("flush_other_dd", 24'(DD), 24'h0);
                    DA = save_da;
                end
            end
        end
        m_tag[bi]   = row;
        m_valid[bi] = !flushed;
        m_data[bi]  = img[row];
        // A flush stands for a CPU write: the row's SDRAM content changes.
        if (flushed)
            for (int b = 0; b < 32; b++) img[row][b] = 8'($urandom);
        model_touch(DA);
    endtask

    task automatic step_da(input logic [11:0] da);
        logic [7:0] e_dd;
        logic       e_un;
        logic [6:0] r;
        int         b;
        e_dd = exp_dd(da);
        e_un = (hit_idx(da) < 0);
        DA = da;
        tick();
        chk("rd_dd", 24'(DD), 24'(e_dd));
        chk("rd_underrun", 24'(underrun), 24'(e_un));
        model_touch(da);
        for (int i = 0; i < 4; i++) begin
            if (!predict(DA, r, b)) break;
            serve_fill();
        end
        tick();
        tick();
        chk("no_extra_req", 24'(mem_req), 24'h0);
    endtask

    initial begin
        reset      = 1'b1;
        DA         = 12'h000;
        flush      = 1'b0;
        mem_ack    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 16'h0;
        rowset     = '{7'd0, 7'd1, 7'd2, 7'd3, 7'd126, 7'd127};
        for (int r = 0; r < 128; r++)
            for (int b = 0; b < 32; b++)
                img[r][b] = (r == 0) ? 8'(b) : 8'($urandom);
        model_reset();
        repeat (3) tick();
        chk_reset_outputs();
        reset = 1'b0;

        // Cold demand fill of row 0, then prefetch of row 1.
        step_da(12'h000);
        step_da(12'h005);
        step_da(12'h025);
        // Jump to row 2: demand into the LRU entry, then prefetch row 3.
        step_da(12'h040);
        step_da(12'h05F);
        step_da(12'h061);
        // Row 127 and the wrap to row 0.
        step_da(12'hFE0);
        step_da(12'hFFF);
        step_da(12'h003);
        // Flush after beat 7 of a demand fill.
        g_flush_beat = 7;
        step_da(12'h200);
        // Spurious ack/rvalid while idle, then byte-exact reads.
        repeat (5) begin
            mem_rvalid = 1'b1;
            mem_ack    = 1'b1;
            mem_rdata  = 16'($urandom);
            tick();
            chk("spurious_no_req", 24'(mem_req), 24'h0);
        end
        mem_rvalid = 1'b0;
        mem_ack    = 1'b0;
        for (int b = 0; b < 32; b++) step_da({7'd16, 5'(b)});
        for (int b = 0; b < 32; b++) step_da({7'd17, 5'(b)});
        // Flush in the same clock as a demand decision: no launch that clock.
        model_touch(DA);
        DA    = 12'h4A0;
        flush = 1'b1;
        tick();
        flush   = 1'b0;
        m_valid = '{0, 0};
        chk("flush_wins_no_req", 24'(mem_req), 24'h0);
        step_da(12'h4A0);
        // Randomised walk over a few rows, including the wrap.
        repeat (24) step_da({rowset[$urandom_range(0, 5)], 5'($urandom_range(0, 31))});
        // Reset during beat 10, then a fresh demand fetch.
        g_reset_beat = 10;
        step_da(12'h300);
        step_da(12'h30A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
